// File: rtl/branch_condition_unit.sv
// branch_condition_unit
// Execute-stage branch resolver. It holds the architectural flag register
// {N,Z,C,V} and evaluates the branch condition against the stored flags.
// A taken branch produces a one-cycle registered PC redirect and a flush
// of the wrong-path instructions in IF/ID that lasts several cycles. The
// unit also keeps saturating profiling counters.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   Stall           freeze: no state update, no branch accepted
//   FlagWrite       load Flags from ALUFlags
//   BranchInst      the EX instruction is a branch
//   CondFlag        condition code (AL,EQ,NE,LT,GT,LE,GE,NV)
//   ALUFlags        {N,Z,C,V} from the ALU
//   BranchTarget    computed target address
//   Flags           registered flag register
//   BranchTaken     combinational: accepted branch whose condition holds
//   PCSrc/PCTarget  registered redirect strobe and address
//   FlushOut        squash IF/ID while the flush counter is nonzero
//   BranchCount     saturating count of accepted branches
//   TakenCount      saturating count of taken branches
module branch_condition_unit #(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Stall,
  input  logic              FlagWrite,
  input  logic              BranchInst,
  input  logic [2:0]        CondFlag,
  input  logic [3:0]        ALUFlags,
  input  logic [ADDR_W-1:0] BranchTarget,
  output logic [3:0]        Flags,
  output logic              BranchTaken,
  output logic              PCSrc,
  output logic [ADDR_W-1:0] PCTarget,
  output logic              FlushOut,
  output logic [CNT_W-1:0]  BranchCount,
  output logic [CNT_W-1:0]  TakenCount
);

  localparam logic [2:0] COND_AL = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_NE = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_GT = 3'b100;
  localparam logic [2:0] COND_LE = 3'b101;
  localparam logic [2:0] COND_GE = 3'b110;

  localparam logic [2:0]       FLUSH_LOAD = 3'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  logic       flag_n;
  logic       flag_z;
  logic       flag_v;
  logic       cond_true;
  logic       accept;
  logic [2:0] flush_cnt;

  // Condition always uses the stored flags; a same-cycle FlagWrite only
  // becomes visible to the next instruction.
  assign flag_n = Flags[3];
  assign flag_z = Flags[2];
  assign flag_v = Flags[0];

  always_comb begin
    cond_true = 1'b0;
    case (CondFlag)
      COND_AL: cond_true = 1'b1;
      COND_EQ: cond_true = flag_z;
      COND_NE: cond_true = !flag_z;
      COND_LT: cond_true = (flag_n != flag_v);
      COND_GT: cond_true = !flag_z && (flag_n == flag_v);
      COND_LE: cond_true = flag_z || (flag_n != flag_v);
      COND_GE: cond_true = (flag_n == flag_v);
      default: cond_true = 1'b0;
    endcase
  end

  // Branches seen while flushing are on the wrong path and are dropped.
  assign accept      = BranchInst && !Stall && !FlushOut;
  assign BranchTaken = accept && cond_true;
  assign FlushOut    = (flush_cnt != 3'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      Flags       <= 4'b0000;
      PCSrc       <= 1'b0;
      PCTarget    <= '0;
      flush_cnt   <= 3'd0;
      BranchCount <= '0;
      TakenCount  <= '0;
    end else begin
      // Redirect is a single-cycle strobe; a stall always clears it.
      PCSrc <= BranchTaken;
      if (BranchTaken)
        PCTarget <= BranchTarget;

      if (!Stall) begin
        if (FlagWrite)
          Flags <= ALUFlags;

        if (BranchTaken)
          flush_cnt <= FLUSH_LOAD;
        else if (flush_cnt != 3'd0)
          flush_cnt <= flush_cnt - 3'd1;
      end

      if (accept && (BranchCount != CNT_MAX))
        BranchCount <= BranchCount + 1'b1;
      if (BranchTaken && (TakenCount != CNT_MAX))
        TakenCount <= TakenCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_condition_unit.sv
module tb_branch_condition_unit;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              Stall;
  logic              FlagWrite;
  logic              BranchInst;
  logic [2:0]        CondFlag;
  logic [3:0]        ALUFlags;
  logic [ADDR_W-1:0] BranchTarget;

  logic [3:0]        Flags;
  logic              BranchTaken;
  logic              PCSrc;
  logic [ADDR_W-1:0] PCTarget;
  logic              FlushOut;
  logic [15:0]       BranchCount;
  logic [15:0]       TakenCount;

  logic [3:0]        s_Flags;
  logic              s_BranchTaken;
  logic              s_PCSrc;
  logic [ADDR_W-1:0] s_PCTarget;
  logic              s_FlushOut;
  logic [3:0]        s_BranchCount;
  logic [3:0]        s_TakenCount;

  int checks = 0;
  int errors = 0;
  logic [ADDR_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  branch_condition_unit #(.ADDR_W(ADDR_W), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .Stall(Stall), .FlagWrite(FlagWrite),
    .BranchInst(BranchInst), .CondFlag(CondFlag), .ALUFlags(ALUFlags),
    .BranchTarget(BranchTarget), .Flags(Flags), .BranchTaken(BranchTaken),
    .PCSrc(PCSrc), .PCTarget(PCTarget), .FlushOut(FlushOut),
    .BranchCount(BranchCount), .TakenCount(TakenCount)
  );

  // Narrow-counter instance on the same stimulus for saturation.
  branch_condition_unit #(.ADDR_W(ADDR_W), .FLUSH_CYCLES(2), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .Stall(Stall), .FlagWrite(FlagWrite),
    .BranchInst(BranchInst), .CondFlag(CondFlag), .ALUFlags(ALUFlags),
    .BranchTarget(BranchTarget), .Flags(s_Flags), .BranchTaken(s_BranchTaken),
    .PCSrc(s_PCSrc), .PCTarget(s_PCTarget), .FlushOut(s_FlushOut),
    .BranchCount(s_BranchCount), .TakenCount(s_TakenCount)
  );

  // Monitor: every redirect strobe must match the next expected target.
  always @(negedge clk) begin
    if (PCSrc === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL redirect_unexpected PCTarget=%h with no redirect expected", PCTarget);
      end else begin
        logic [ADDR_W-1:0] e;
        e = exp_q.pop_front();
        if (PCTarget !== e) begin
          errors++;
          $display("FAIL redirect_target got=%h exp=%h", PCTarget, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic fw, input logic bi,
                       input logic [2:0] cond, input logic [3:0] alu,
                       input logic [ADDR_W-1:0] tgt);
    Stall = st; FlagWrite = fw; BranchInst = bi;
    CondFlag = cond; ALUFlags = alu; BranchTarget = tgt;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 4'b0000, '0);
  endtask

  // Bounded wait for the flush to drain.
  task automatic wait_flush();
    int n;
    n = 0;
    idle();
    while (FlushOut && n < 10) begin
      tick();
      n++;
    end
    if (FlushOut) begin
      checks++;
      errors++;
      $display("FAIL flush_timeout FlushOut=%0b exp=0", FlushOut);
    end
  endtask

  // Issue one branch: check BranchTaken, queue a redirect if taken, advance.
  task automatic branch(input logic [2:0] cond, input logic [ADDR_W-1:0] tgt,
                        input logic exp_taken, input string name);
    drive(1'b0, 1'b0, 1'b1, cond, 4'b0000, tgt);
    chk(name, BranchTaken, exp_taken);
    if (exp_taken) exp_q.push_back(tgt);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    chk("reset_flags", Flags, 4'b0000);
    chk("reset_pcsrc", PCSrc, 1'b0);
    chk("reset_pctarget", PCTarget, 0);
    chk("reset_flush", FlushOut, 1'b0);
    chk("reset_bcount", BranchCount, 0);
    chk("reset_tcount", TakenCount, 0);
    rst = 1'b0;

    // CMP then BEQ
    drive(1'b0, 1'b1, 1'b0, 3'b000, 4'b0100, '0);
    tick();
    chk("cmp_flags", Flags, 4'b0100);
    branch(3'b001, 32'h40, 1'b1, "beq_taken");
    idle();
    chk("beq_flush_c3", FlushOut, 1'b1);
    chk("beq_tcount", TakenCount, 1);
    chk("beq_bcount", BranchCount, 1);
    tick();
    chk("beq_flush_c4", FlushOut, 1'b1);
    tick();
    chk("beq_flush_c5", FlushOut, 1'b0);
    chk("beq_pctarget_hold", PCTarget, 32'h40);

    // Same-cycle FlagWrite and BNE: old Z=0 decides
    drive(1'b0, 1'b1, 1'b0, 3'b000, 4'b0000, '0);
    tick();
    drive(1'b0, 1'b1, 1'b1, 3'b010, 4'b0100, 32'h80);
    chk("bne_old_flags", BranchTaken, 1'b1);
    exp_q.push_back(32'h80);
    tick();
    idle();
    chk("bne_new_flags", Flags, 4'b0100);
    chk("bne_flush", FlushOut, 1'b1);
    wait_flush();

    // Condition code is ignored without BranchInst
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 1'b0, 1'b0, 3'(c), 4'b0000, 32'hDEAD);
      chk("nonbranch_taken", BranchTaken, 1'b0);
    end
    tick();
    chk("nonbranch_pcsrc", PCSrc, 1'b0);

    // Wrong-path squash
    branch(3'b000, 32'h100, 1'b1, "al_first");
    branch(3'b000, 32'h200, 1'b0, "al_wrongpath");
    idle();
    chk("wp_bcount", BranchCount, 3);
    chk("wp_tcount", TakenCount, 3);
    wait_flush();

    // Stall freeze
    branch(3'b000, 32'h300, 1'b1, "stall_pre_branch");
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 3'b000, 4'b1111, 32'h3F0);
      chk("stall_taken", BranchTaken, 1'b0);
      tick();
      chk("stall_flush_hold", FlushOut, 1'b1);
      chk("stall_pcsrc", PCSrc, 1'b0);
    end
    chk("stall_flags_hold", Flags, 4'b0100);
    chk("stall_bcount", BranchCount, 4);
    chk("stall_tcount", TakenCount, 4);
    idle();
    tick();
    chk("release_flush_1", FlushOut, 1'b1);
    tick();
    chk("release_flush_2", FlushOut, 1'b0);
    chk("stall_pctarget", PCTarget, 32'h300);

    // Signed conditions with N=1, V=0, Z=0
    drive(1'b0, 1'b1, 1'b0, 3'b000, 4'b1000, '0);
    tick();
    branch(3'b011, 32'h400, 1'b1, "lt_taken");
    wait_flush();
    branch(3'b110, 32'h410, 1'b0, "ge_not_taken");
    branch(3'b101, 32'h500, 1'b1, "le_taken");
    wait_flush();
    branch(3'b111, 32'h510, 1'b0, "nv_never");
    branch(3'b100, 32'h520, 1'b0, "gt_not_taken");
    branch(3'b001, 32'h530, 1'b0, "eq_not_taken");
    idle();
    chk("signed_bcount", BranchCount, 10);
    chk("signed_tcount", TakenCount, 6);

    // Saturation on the narrow instance: 17 more taken branches
    for (int i = 0; i < 17; i++) begin
      branch(3'b000, 32'h1000 + 32'(i * 4), 1'b1, "sat_branch");
      wait_flush();
    end
    chk("sat_tcount4", s_TakenCount, 4'hF);
    chk("sat_bcount4", s_BranchCount, 4'hF);
    chk("wide_tcount", TakenCount, 23);
    chk("wide_bcount", BranchCount, 27);

    // Reset mid-flush
    branch(3'b000, 32'hA00, 1'b1, "rst_pre_branch");
    idle();
    chk("rst_pre_flush", FlushOut, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_flush", FlushOut, 1'b0);
    chk("rst_mid_pcsrc", PCSrc, 1'b0);
    chk("rst_mid_flags", Flags, 4'b0000);
    chk("rst_mid_bcount", BranchCount, 0);
    chk("rst_mid_tcount", TakenCount, 0);
    chk("rst_mid_pctarget", PCTarget, 0);
    tick();
    chk("rst_after_flush", FlushOut, 1'b0);

    tick();
    tick();
    chk("redirects_outstanding", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_condition_unit.md
Name: branch_condition_unit

Overview:
- Execute-stage companion to the control decoder. It owns the architectural flag register {N,Z,C,V}, which is written when the decoder asserts FlagWrite (register-form CMP).
- It evaluates the 3-bit branch condition whenever BranchInst is high, and produces a registered PC redirect for fetch plus a multi-cycle flush of wrong-path instructions.
- It keeps saturating counters of branches evaluated and branches taken, for profiling.

Parameters:
- ADDR_W, 32, width of branch target and redirected PC.
- FLUSH_CYCLES, 2, number of cycles FlushOut stays high after a taken branch; legal range 1..7.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- Stall  in  1  pipeline freeze; when high, no state updates and no branch is evaluated
- FlagWrite  in  1  from decoder; load Flags from ALUFlags this cycle
- BranchInst  in  1  from decoder; current EX instruction is a branch
- CondFlag  in  3  from decoder; branch condition code
- ALUFlags  in  4  {N,Z,C,V} from the ALU for the current EX instruction
- BranchTarget  in  ADDR_W  computed branch target (ALU result)
- Flags  out  4  registered flag register {N,Z,C,V}
- BranchTaken  out  1  combinational: current branch is taken and accepted
- PCSrc  out  1  registered one-cycle redirect strobe to fetch
- PCTarget  out  ADDR_W  registered redirect address; valid when PCSrc=1
- FlushOut  out  1  registered; squash IF/ID contents
- BranchCount  out  CNT_W  saturating count of accepted branches
- TakenCount  out  CNT_W  saturating count of taken branches

Behaviour:
- Reset (rst=1 at a clock edge):
  - Flags, PCSrc, PCTarget, FlushOut, BranchCount, TakenCount and the internal flush counter all go to 0.
  - Reset has priority over every other input, including a flush in progress or a stall.
- Condition decode, always evaluated against the stored Flags, not ALUFlags:
  - 000 AL: always
  - 001 EQ: Z
  - 010 NE: !Z
  - 011 LT: N!=V
  - 100 GT: !Z && N==V
  - 101 LE: Z || N!=V
  - 110 GE: N==V
  - 111 NV: never
- Accept: accept = BranchInst && !Stall && !FlushOut. BranchTaken = accept && cond_true.
- Flag update: if FlagWrite && !Stall, Flags <= ALUFlags at the edge.
  - A branch in the cycle after a flag-writing instruction sees the new flags; no forwarding path.
  - Same-cycle FlagWrite and BranchInst: the branch uses the old flags; Flags then update.
- Redirect: a taken branch in cycle N gives PCSrc=1 and PCTarget=BranchTarget(N) in cycle N+1 only.
  - PCSrc is 0 in every other cycle. PCTarget holds its last value when PCSrc=0.
- Flush:
  - On a taken branch, the internal counter loads FLUSH_CYCLES.
  - FlushOut = (counter!=0), registered, so it is high in cycles N+1 .. N+FLUSH_CYCLES.
  - The counter decrements each non-stalled cycle while nonzero.
  - Branches arriving while FlushOut=1 are wrong-path: they are ignored and not counted.
- Stall:
  - Flags, the counter and the statistics counters hold.
  - PCSrc is forced to 0 on the next edge. PCTarget and FlushOut hold.
  - A taken branch cannot occur during a stall because accept=0.
- Statistics:
  - BranchCount increments on each accept; TakenCount on each BranchTaken.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Non-branch instructions (BranchInst=0): CondFlag is don't-care and must not affect any output.

Test Plan:
- Reset mid-flush: taken branch, then rst=1 in cycle N+1 -> next cycle FlushOut=0, PCSrc=0, Flags=0000, both counters=0.
- CMP then BEQ: FlagWrite=1 with ALUFlags=0100 in cycle 1; BranchInst=1, CondFlag=001, BranchTarget=0x40 in cycle 2 -> BranchTaken=1 in cycle 2; PCSrc=1 and PCTarget=0x40 in cycle 3; FlushOut=1 in cycles 3-4; TakenCount=1.
- Same-cycle ordering: Flags=0000, then FlagWrite=1 with ALUFlags=0100 alongside BNE (010) -> taken (old Z=0); Flags=0100 next cycle.
- Wrong-path squash: taken AL branch in cycle 1, then another AL branch in cycle 2 (FlushOut=1) -> second branch not taken; BranchCount=1; PCSrc high for exactly one cycle.
- Stall freeze: FlushOut=1 with counter=2, then Stall=1 for 3 cycles -> FlushOut stays 1 and the counter holds; after release FlushOut falls 2 cycles later. A BranchInst issued under stall leaves counters unchanged.
- Signed conditions and saturation:
  - Flags N=1, V=0: LT taken, GE not taken, LE taken, NV never taken.
  - With CNT_W=4 and 17 taken branches: TakenCount=15.
